// File: rtl/exc_ctrl.sv
// exc_ctrl: M-stage exception/ERET sequencer; pulses CP0 once, then flushes and holds a redirect until fetch accepts it.
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic        m_in_ds,
    input  logic [5:0]  m_exc,
    input  logic        m_ades,
    input  logic [31:0] m_mem_addr,
    input  logic        m_eret,
    input  logic        interrupt,
    input  logic [31:0] cp0_epc,
    output logic        exception,
    output logic [5:0]  m_excCode,
    output logic        isBadAddr,
    output logic [31:0] invalid_addr,
    output logic [31:0] excPC,
    output logic        inDelaySlot,
    output logic        ERET2pc,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);
    typedef enum logic [1:0] {IDLE, PULSE, WAIT} state_t;

    state_t      state_q, state_d;
    logic        eret_q, eret_d, bad_q, bad_d, ds_q;
    logic [5:0]  code_q, code_d;
    logic [31:0] baddr_q, baddr_d, pc_q, target_q, target_d;
    logic        any_exc, trigger, pulse, busy;

    // m_exc = {AdEL_if, RI, Ov, Sys, Bp, AdEL_d}
    always_comb begin
        any_exc  = interrupt | (|m_exc) | m_ades;
        trigger  = m_valid & (any_exc | m_eret);
        code_d   = interrupt ? 6'd0  :
                   m_exc[5]  ? 6'd4  :
                   m_exc[4]  ? 6'd10 :
                   m_exc[3]  ? 6'd12 :
                   m_exc[2]  ? 6'd8  :
                   m_exc[1]  ? 6'd9  :
                   m_exc[0]  ? 6'd4  :
                   m_ades    ? 6'd5  : 6'd0;
        bad_d    = !interrupt & (m_exc[5] | (m_exc[4:1] == 4'd0 & (m_exc[0] | m_ades)));
        baddr_d  = !bad_d ? 32'd0 : m_exc[5] ? m_pc : m_mem_addr;
        eret_d   = !any_exc;
        target_d = any_exc ? EXC_VECTOR : cp0_epc;
        state_d  = state_q == IDLE ? (trigger ? PULSE : IDLE) : (redirect_ready ? IDLE : WAIT);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            eret_q   <= 1'b0;
            bad_q    <= 1'b0;
            ds_q     <= 1'b0;
            code_q   <= 6'd0;
            baddr_q  <= 32'd0;
            pc_q     <= 32'd0;
            target_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && trigger) begin
                eret_q   <= eret_d;
                bad_q    <= bad_d;
                ds_q     <= m_in_ds;
                code_q   <= code_d;
                baddr_q  <= baddr_d;
                pc_q     <= m_pc;
                target_q <= target_d;
            end
        end
    end

    assign pulse          = state_q == PULSE;
    assign busy           = state_q != IDLE;
    assign exception      = pulse & !eret_q;
    assign ERET2pc        = pulse & eret_q;
    assign m_excCode      = exception ? code_q : 6'd0;
    assign isBadAddr      = exception & bad_q;
    assign invalid_addr   = exception ? baddr_q : 32'd0;
    assign excPC          = exception ? pc_q : 32'd0;
    assign inDelaySlot    = exception & ds_q;
    assign flush          = busy;
    assign redirect_valid = busy;
    assign redirect_pc    = busy ? target_q : 32'd0;
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed vectors with a queue scoreboard checked by a negedge monitor on each CP0 pulse.
module tb_exc_ctrl;
    localparam logic [31:0] VEC = 32'hBFC0_0380;

    typedef struct packed {
        logic        exc;
        logic        eret;
        logic [5:0]  code;
        logic        bad;
        logic [31:0] addr;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] rpc;
    } exp_t;

    logic        clk = 1'b0, resetn = 1'b0;
    logic        m_valid = 1'b0, m_in_ds = 1'b0, m_ades = 1'b0, m_eret = 1'b0, interrupt = 1'b0;
    logic [31:0] m_pc = '0, m_mem_addr = '0, cp0_epc = '0;
    logic [5:0]  m_exc = '0;
    logic        redirect_ready = 1'b0;
    logic        exception, isBadAddr, inDelaySlot, ERET2pc, flush, redirect_valid;
    logic [5:0]  m_excCode;
    logic [31:0] invalid_addr, excPC, redirect_pc;

    exp_t sb[$];
    int   compared = 0, mismatched = 0, rv_cnt = 0;

    exc_ctrl dut (
        .clk(clk), .resetn(resetn), .m_valid(m_valid), .m_pc(m_pc), .m_in_ds(m_in_ds),
        .m_exc(m_exc), .m_ades(m_ades), .m_mem_addr(m_mem_addr), .m_eret(m_eret),
        .interrupt(interrupt), .cp0_epc(cp0_epc), .exception(exception), .m_excCode(m_excCode),
        .isBadAddr(isBadAddr), .invalid_addr(invalid_addr), .excPC(excPC),
        .inDelaySlot(inDelaySlot), .ERET2pc(ERET2pc), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ready(redirect_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic exc, input logic [5:0] code, input logic bad,
                                input logic [31:0] addr, input logic [31:0] pc, input logic ds,
                                input logic [31:0] rpc);
        return '{exc: exc, eret: !exc, code: code, bad: bad, addr: addr, pc: pc, ds: ds, rpc: rpc};
    endfunction

    always @(negedge clk) begin
        if (redirect_valid) rv_cnt++;
        if (exception || ERET2pc) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_pulse: got exception=%0b ERET2pc=%0b expected none", exception, ERET2pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("exception", 32'(exception), 32'(e.exc));
                chk("ERET2pc", 32'(ERET2pc), 32'(e.eret));
                chk("m_excCode", 32'(m_excCode), 32'(e.code));
                chk("isBadAddr", 32'(isBadAddr), 32'(e.bad));
                chk("invalid_addr", invalid_addr, e.addr);
                chk("excPC", excPC, e.pc);
                chk("inDelaySlot", 32'(inDelaySlot), 32'(e.ds));
                chk("redirect_pc", redirect_pc, e.rpc);
                chk("pulse_flush", 32'({flush, redirect_valid}), 32'b11);
            end
        end
    end

    task automatic clear_m();
        m_valid = 0; m_pc = '0; m_in_ds = 0; m_exc = '0; m_ades = 0;
        m_mem_addr = '0; m_eret = 0; interrupt = 0; cp0_epc = '0;
    endtask

    task automatic set_m(input logic [31:0] pc, input logic ds, input logic [5:0] exc,
                         input logic ades, input logic [31:0] maddr, input logic eret,
                         input logic intr, input logic [31:0] epc);
        m_valid = 1; m_pc = pc; m_in_ds = ds; m_exc = exc; m_ades = ades;
        m_mem_addr = maddr; m_eret = eret; interrupt = intr; cp0_epc = epc;
    endtask

    // Inputs already set; trigger edge N, ready withheld for 'delay' cycles starting at N+1.
    task automatic fire(input string name, input exp_t e, input int delay);
        int base;
        sb.push_back(e);
        @(posedge clk); #1;
        clear_m();
        base = rv_cnt;
        redirect_ready = (delay == 0);
        for (int i = 0; i < delay; i++) begin
            @(posedge clk); #1;
            redirect_ready = (i == delay - 1);
        end
        @(posedge clk); #1;
        redirect_ready = 0;
        @(negedge clk);
        chk({name, "_idle_after"}, 32'({redirect_valid, flush}), 32'b0);
        chk({name, "_rv_cycles"}, 32'(rv_cnt - base), 32'(delay + 1));
    endtask

    initial begin
        int base;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 32'({exception, ERET2pc, flush, redirect_valid, isBadAddr, inDelaySlot,
                                  |m_excCode, |invalid_addr, |excPC, |redirect_pc}), 32'b0);
        resetn = 1;

        set_m(32'h8000_0100, 0, 6'b000100, 0, 32'h0, 0, 0, 32'h0);
        fire("sys", mk(1, 6'd8, 0, 32'h0, 32'h8000_0100, 0, VEC), 0);

        set_m(32'h8000_0104, 1, 6'b000001, 0, 32'h8000_0003, 0, 0, 32'h0);
        fire("adel_d", mk(1, 6'd4, 1, 32'h8000_0003, 32'h8000_0104, 1, VEC), 3);

        set_m(32'h8000_0108, 0, 6'b000000, 0, 32'h0, 1, 0, 32'h8000_0200);
        fire("eret", mk(0, 6'd0, 0, 32'h0, 32'h0, 0, 32'h8000_0200), 1);

        set_m(32'h8000_0300, 0, 6'b010000, 0, 32'h0, 1, 1, 32'h8000_0200);
        fire("int_prio", mk(1, 6'd0, 0, 32'h0, 32'h8000_0300, 0, VEC), 0);

        set_m(32'h8000_0304, 0, 6'b000000, 0, 32'h0, 0, 1, 32'h0);
        m_valid = 0;
        base = rv_cnt;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("int_no_valid_rv", 32'(rv_cnt - base), 32'd0);
        clear_m();

        set_m(32'h8000_0001, 0, 6'b101000, 0, 32'h0000_1234, 0, 0, 32'h0);
        fire("adel_if", mk(1, 6'd4, 1, 32'h8000_0001, 32'h8000_0001, 0, VEC), 0);

        set_m(32'h8000_0400, 0, 6'b000000, 1, 32'h8000_0406, 0, 0, 32'h0);
        fire("ades", mk(1, 6'd5, 1, 32'h8000_0406, 32'h8000_0400, 0, VEC), 2);

        set_m(32'h8000_0404, 0, 6'b001000, 0, 32'h0, 0, 0, 32'h0);
        fire("ov", mk(1, 6'd12, 0, 32'h0, 32'h8000_0404, 0, VEC), 0);

        set_m(32'h8000_0408, 0, 6'b000100, 0, 32'h0, 0, 0, 32'h0);
        sb.push_back(mk(1, 6'd8, 0, 32'h0, 32'h8000_0408, 0, VEC));
        @(posedge clk); #1;
        clear_m();
        redirect_ready = 0;
        @(posedge clk); #1;
        chk("wait_rv", 32'(redirect_valid), 32'd1);
        resetn = 0;
        @(posedge clk); #1;
        chk("reset_in_wait", 32'({exception, ERET2pc, flush, redirect_valid, isBadAddr, inDelaySlot,
                                  |m_excCode, |invalid_addr, |excPC, |redirect_pc}), 32'b0);
        resetn = 1;
        @(negedge clk);
        chk("reset_stays_idle", 32'(redirect_valid), 32'd0);

        set_m(32'h8000_0500, 1, 6'b000010, 0, 32'h0, 0, 0, 32'h0);
        fire("bp", mk(1, 6'd9, 0, 32'h0, 32'h8000_0500, 1, VEC), 0);

        repeat (2) @(posedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
